// File: rtl/mem_access.sv
// mem_access: memory pipeline stage with a req/ack data port and registered writeback outputs.
// Optional define MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap (or_misaligned) instead of issuing.
module mem_access #(
   parameter int XLEN  = 32,
   parameter int OPLEN = 6,
   parameter int XADDR = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [OPLEN:0]   i_opcode,
   input  logic [XADDR-1:0] i_rd_addr,
   input  logic [XLEN-1:0]  i_alu_result,
   input  logic [XLEN-1:0]  i_rs2_data,
   input  logic [2:0]       i_funct3,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_pc_next,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic [XLEN-1:0]  o_dmem_addr,
   output logic [XLEN-1:0]  o_dmem_wdata,
   output logic [3:0]       o_dmem_be,
   input  logic             i_dmem_ack,
   input  logic [XLEN-1:0]  i_dmem_rdata,
   output logic             o_stall,
   output logic             or_valid,
   output logic [OPLEN:0]   or_opcode,
   output logic [XADDR-1:0] or_rd_addr,
   output logic [XLEN-1:0]  or_rd_data,
   output logic             or_rd_wr_en,
   output logic [XLEN-1:0]  or_pc
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic             or_misaligned
`endif
);

   localparam logic [OPLEN:0] OP_R     = 7'b0110011;
   localparam logic [OPLEN:0] OP_I     = 7'b0010011;
   localparam logic [OPLEN:0] OP_L     = 7'b0000011;
   localparam logic [OPLEN:0] OP_S     = 7'b0100011;
   localparam logic [OPLEN:0] OP_LUI   = 7'b0110111;
   localparam logic [OPLEN:0] OP_AUIPC = 7'b0010111;
   localparam logic [OPLEN:0] OP_JAL   = 7'b1101111;
   localparam logic [OPLEN:0] OP_JALR  = 7'b1100111;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t            state_r;
   logic [OPLEN:0]    op_r;
   logic [XADDR-1:0]  rd_r;
   logic [2:0]        f3_r;
   logic [1:0]        lane_r;
   logic [XLEN-1:0]   pc_r;

   logic [1:0]        lane_s;
   logic              mem_op_s;
   logic              trap_s;
   logic              issue_s;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   lane_be = 4'b0001 << a;
         2'b01:   lane_be = 4'b0011 << a;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [XLEN-1:0] word);
      logic [XLEN-1:0] sh;
      sh = word >> {a, 3'b000};
      case (f3)
         3'b000:  load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
         3'b001:  load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [OPLEN:0] op);
      case (op)
         OP_R, OP_I, OP_L, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
         default:                                             writes_rd = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] wb_value(input logic [OPLEN:0] op, input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pcn);
      case (op)
         OP_JAL, OP_JALR: wb_value = pc + XLEN'(3'd4);
         OP_AUIPC:        wb_value = pcn;
         default:         wb_value = alu;
      endcase
   endfunction

   assign lane_s   = i_alu_result[1:0];
   assign mem_op_s = i_valid && ((i_opcode == OP_L) || (i_opcode == OP_S));
   assign issue_s  = mem_op_s && !trap_s;

`ifdef MEM_MISALIGN_TRAP_EN
   // Halfword accesses need an even address, word accesses a word-aligned one.
   always_comb begin
      trap_s = 1'b0;
      if (mem_op_s) begin
         case (i_funct3[1:0])
            2'b01:   trap_s = lane_s[0];
            2'b10:   trap_s = (lane_s != 2'b00);
            default: trap_s = 1'b0;
         endcase
      end else begin
         trap_s = 1'b0;
      end
   end
`else
   assign trap_s = 1'b0;
`endif

   // Upstream must freeze while a request is being issued or is still waiting for its ack.
   always_comb begin
      o_stall = 1'b0;
      if (i_rst) begin
         o_stall = 1'b0;
      end else if (state_r == ST_BUSY) begin
         o_stall = !i_dmem_ack;
      end else begin
         o_stall = issue_s;
      end
   end

   // Stage FSM: pass-through in IDLE, hold the bus request in BUSY until ack.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         op_r         <= '0;
         rd_r         <= '0;
         f3_r         <= 3'b000;
         lane_r       <= 2'b00;
         pc_r         <= '0;
         o_dmem_req   <= 1'b0;
         o_dmem_we    <= 1'b0;
         o_dmem_addr  <= '0;
         o_dmem_wdata <= '0;
         o_dmem_be    <= 4'b0000;
         or_valid     <= 1'b0;
         or_opcode    <= '0;
         or_rd_addr   <= '0;
         or_rd_data   <= '0;
         or_rd_wr_en  <= 1'b0;
         or_pc        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         or_misaligned <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
               or_misaligned <= 1'b0;
`endif
               if (issue_s) begin
                  state_r      <= ST_BUSY;
                  op_r         <= i_opcode;
                  rd_r         <= i_rd_addr;
                  f3_r         <= i_funct3;
                  lane_r       <= lane_s;
                  pc_r         <= i_pc;
                  o_dmem_req   <= 1'b1;
                  o_dmem_we    <= (i_opcode == OP_S);
                  o_dmem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
                  o_dmem_wdata <= i_rs2_data << {lane_s, 3'b000};
                  o_dmem_be    <= lane_be(i_funct3[1:0], lane_s);
                  or_valid     <= 1'b0;
                  or_rd_wr_en  <= 1'b0;
               end else if (i_valid) begin
                  or_valid     <= 1'b1;
                  or_opcode    <= i_opcode;
                  or_rd_addr   <= i_rd_addr;
                  or_pc        <= i_pc;
                  or_rd_data   <= wb_value(i_opcode, i_alu_result, i_pc, i_pc_next);
                  or_rd_wr_en  <= writes_rd(i_opcode) && (i_rd_addr != '0) && !trap_s;
`ifdef MEM_MISALIGN_TRAP_EN
                  or_misaligned <= trap_s;
`endif
               end else begin
                  or_valid     <= 1'b0;
                  or_rd_wr_en  <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (i_dmem_ack) begin
                  state_r     <= ST_IDLE;
                  o_dmem_req  <= 1'b0;
                  or_valid    <= 1'b1;
                  or_opcode   <= op_r;
                  or_rd_addr  <= rd_r;
                  or_pc       <= pc_r;
                  or_rd_wr_en <= (op_r == OP_L) && (rd_r != '0);
                  if (op_r == OP_L) begin
                     or_rd_data <= load_ext(f3_r, lane_r, i_dmem_rdata);
                  end else begin
                     or_rd_data <= {o_dmem_addr[XLEN-1:2], lane_r};
                  end
               end else begin
                  or_valid    <= 1'b0;
                  or_rd_wr_en <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               o_dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed spec cases plus random instruction stream vs. a transaction-level model.
module tb_mem_access;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_FENCE = 7'b0001111;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] pcn;
   } instr_t;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] rd_data;
      logic        wr_en;
      logic        chk_data;
      logic        mis;
      logic        mem;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [6:0]  i_opcode;
   logic [4:0]  i_rd_addr;
   logic [31:0] i_alu_result, i_rs2_data, i_pc, i_pc_next, i_dmem_rdata;
   logic [2:0]  i_funct3;
   logic        i_dmem_ack;
   logic        o_dmem_req, o_dmem_we, o_stall;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        or_valid, or_rd_wr_en;
   logic [6:0]  or_opcode;
   logic [4:0]  or_rd_addr;
   logic [31:0] or_rd_data, or_pc;
   logic        or_misaligned;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int req_cnt = 0;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   logic chk_en = 1'b0;
   logic exp_stall = 1'b0, exp_req = 1'b0, exp_valid = 1'b0;
   exp_t exp_wb = '0, exp_mem = '0;

   mem_access dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_opcode(i_opcode), .i_rd_addr(i_rd_addr),
      .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_funct3(i_funct3), .i_pc(i_pc),
      .i_pc_next(i_pc_next), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
      .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .or_valid(or_valid), .or_opcode(or_opcode),
      .or_rd_addr(or_rd_addr), .or_rd_data(or_rd_data), .or_rd_wr_en(or_rd_wr_en), .or_pc(or_pc)
`ifdef MEM_MISALIGN_TRAP_EN
      , .or_misaligned(or_misaligned)
`endif
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign or_misaligned = 1'b0;
`endif

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic is_trap(input instr_t t);
      is_trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (t.op == OP_L || t.op == OP_S) begin
         if (t.f3 % 4 == 1 && t.alu % 2 == 1) is_trap = 1'b1;
         if (t.f3 % 4 == 2 && t.alu % 4 != 0) is_trap = 1'b1;
      end
`endif
   endfunction

   // Spec-level model: what the stage must produce for one instruction and its read word.
   function automatic exp_t model(input instr_t t, input logic [31:0] rdata);
      exp_t e;
      int unsigned a;
      logic [31:0] w, b, h, lv;
      logic writes;
      a = t.alu % 4;
      e = '0;
      e.op = t.op; e.rd = t.rd; e.pc = t.pc;
      e.addr  = t.alu - a;
      e.wdata = t.rs2 << (8 * a);
      if (t.f3 % 4 == 0)      e.be = 4'((1 << a));
      else if (t.f3 % 4 == 1) e.be = 4'((3 << a));
      else                    e.be = 4'hF;
      e.we  = (t.op == OP_S);
      e.mis = is_trap(t);
      e.mem = (t.op == OP_L || t.op == OP_S) && !e.mis;
      w = rdata >> (8 * a);
      b = w & 32'h0000_00FF;
      h = w & 32'h0000_FFFF;
      case (t.f3)
         3'd0:    lv = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    lv = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    lv = b;
         3'd5:    lv = h;
         default: lv = w;
      endcase
      if (t.op == OP_L)                         e.rd_data = lv;
      else if (t.op == OP_JAL || t.op == OP_JALR) e.rd_data = t.pc + 32'd4;
      else if (t.op == OP_AUIPC)                e.rd_data = t.pcn;
      else                                      e.rd_data = t.alu;
      writes = (t.op == OP_R) || (t.op == OP_I) || (t.op == OP_L) || (t.op == OP_LUI) ||
               (t.op == OP_AUIPC) || (t.op == OP_JAL) || (t.op == OP_JALR);
      e.wr_en    = writes && (t.rd != 5'd0) && !e.mis;
      e.chk_data = writes && !e.mis;
      return e;
   endfunction

   // Per-cycle comparison of DUT outputs against the current model expectation.
   always @(negedge i_clk) begin
      if (o_stall) stall_cnt++;
      if (o_dmem_req) begin
         req_cnt++;
         last_addr = o_dmem_addr; last_wdata = o_dmem_wdata; last_be = o_dmem_be; last_we = o_dmem_we;
      end
      if (chk_en) begin
         chk("stall", o_stall, exp_stall);
         chk("req", o_dmem_req, exp_req);
         if (exp_req) begin
            chk("addr", o_dmem_addr, exp_mem.addr);
            chk("be", o_dmem_be, exp_mem.be);
            chk("we", o_dmem_we, exp_mem.we);
            if (exp_mem.we) chk("wdata", o_dmem_wdata, exp_mem.wdata);
         end
         chk("valid", or_valid, exp_valid);
         chk("wr_en", or_rd_wr_en, exp_valid && exp_wb.wr_en);
         chk("misaligned", or_misaligned, exp_valid && exp_wb.mis);
         if (exp_valid) begin
            chk("opcode", or_opcode, exp_wb.op);
            chk("rd_addr", or_rd_addr, exp_wb.rd);
            chk("pc", or_pc, exp_wb.pc);
            if (exp_wb.chk_data) chk("rd_data", or_rd_data, exp_wb.rd_data);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input instr_t t);
      i_valid = 1'b1; i_opcode = t.op; i_rd_addr = t.rd; i_alu_result = t.alu;
      i_rs2_data = t.rs2; i_funct3 = t.f3; i_pc = t.pc; i_pc_next = t.pcn;
   endtask

   // Acts as upstream (holds inputs while stalled) and as memory (acks after waitc cycles).
   task automatic do_instr(input instr_t t, input int waitc, input logic [31:0] rdata);
      exp_t e;
      e = model(t, rdata);
      drive(t);
      if (!e.mem) begin
         exp_stall = 1'b0; exp_req = 1'b0;
         tick();
         exp_wb = e; exp_valid = 1'b1;
      end else begin
         exp_stall = 1'b1; exp_req = 1'b0;
         tick();
         exp_valid = 1'b0; exp_req = 1'b1; exp_mem = e;
         for (int k = 0; k < waitc; k++) begin
            i_dmem_rdata = $urandom;
            tick();
         end
         i_dmem_ack = 1'b1; i_dmem_rdata = rdata; exp_stall = 1'b0;
         tick();
         i_dmem_ack = 1'b0; exp_req = 1'b0;
         exp_wb = e; exp_valid = 1'b1;
      end
   endtask

   task automatic bubble();
      i_valid = 1'b0; i_opcode = 7'($urandom); i_alu_result = $urandom;
      exp_stall = 1'b0; exp_req = 1'b0;
      tick();
      exp_valid = 1'b0;
   endtask

   function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [2:0] f3, input logic [31:0] pc);
      instr_t t;
      t.op = op; t.rd = rd; t.alu = alu; t.rs2 = rs2; t.f3 = f3; t.pc = pc; t.pcn = pc + 32'd4;
      return t;
   endfunction

   initial begin
      instr_t t;
      int s0, r0;
      logic [6:0] ops [10];
      logic [2:0] lf3 [5];
      ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE};
      lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      i_rst = 1'b1; i_valid = 1'b0; i_opcode = 7'd0; i_rd_addr = 5'd0; i_alu_result = 32'd0;
      i_rs2_data = 32'd0; i_funct3 = 3'd0; i_pc = 32'd0; i_pc_next = 32'd0;
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      repeat (3) tick();
      chk("rst_req", o_dmem_req, 32'd0);
      chk("rst_stall", o_stall, 32'd0);
      chk("rst_valid", or_valid, 32'd0);
      chk("rst_be", o_dmem_be, 32'd0);
      chk("rst_rd_data", or_rd_data, 32'd0);
      i_rst = 1'b0;
      tick();
      chk_en = 1'b1;

      // SW 0xDEADBEEF @0x100, ack after 3 wait cycles
      s0 = stall_cnt;
      do_instr(mk(OP_S, 5'd3, 32'h100, 32'hDEADBEEF, 3'd2, 32'h10), 3, 32'h0);
      chk("sw_be", last_be, 32'hF);
      chk("sw_addr", last_addr, 32'h100);
      chk("sw_we", last_we, 32'd1);
      chk("sw_stall_cycles", stall_cnt - s0, 32'd4);
      chk("sw_wr_en", or_rd_wr_en, 32'd0);

      do_instr(mk(OP_L, 5'd5, 32'h103, 32'h0, 3'd0, 32'h14), 1, 32'h80FFFFFF);
      chk("lb_data", or_rd_data, 32'hFFFFFF80);
      do_instr(mk(OP_L, 5'd5, 32'h103, 32'h0, 3'd4, 32'h18), 0, 32'h80FFFFFF);
      chk("lbu_data", or_rd_data, 32'h00000080);

      do_instr(mk(OP_S, 5'd0, 32'h202, 32'h1234, 3'd1, 32'h1C), 2, 32'h0);
      chk("sh_be", last_be, 32'hC);
      chk("sh_wdata", last_wdata, 32'h12340000);
      do_instr(mk(OP_L, 5'd6, 32'h202, 32'h0, 3'd5, 32'h20), 0, 32'h12340000);
      chk("lhu_data", or_rd_data, 32'h00001234);

      do_instr(mk(OP_JAL, 5'd1, 32'h999, 32'h0, 3'd0, 32'h40), 0, 32'h0);
      chk("jal_data", or_rd_data, 32'h44);
      chk("jal_wr_en", or_rd_wr_en, 32'd1);
      do_instr(mk(OP_I, 5'd0, 32'h7, 32'h0, 3'd0, 32'h44), 0, 32'h0);
      chk("addi_x0_wr_en", or_rd_wr_en, 32'd0);

      r0 = req_cnt;
      do_instr(mk(OP_L, 5'd7, 32'h101, 32'h0, 3'd2, 32'h48), 1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("lw_mis_flag", or_misaligned, 32'd1);
      chk("lw_mis_noreq", req_cnt - r0, 32'd0);
`else
      chk("lw_mis_addr", last_addr, 32'h100);
      chk("lw_mis_req", (req_cnt - r0) > 0, 32'd1);
`endif
      bubble();
      bubble();

      for (int n = 0; n < 300; n++) begin
         t.op  = ops[$urandom_range(0, 9)];
         t.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         t.alu = $urandom; t.rs2 = $urandom; t.pc = $urandom; t.pcn = $urandom;
         t.f3  = (t.op == OP_S) ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
         do_instr(t, $urandom_range(0, 4), $urandom);
         if ($urandom_range(0, 4) == 0) bubble();
      end

      // Reset in the middle of a pending load; a late ack must be ignored.
      t = mk(OP_L, 5'd9, 32'h300, 32'h0, 3'd2, 32'h80);
      exp_mem = model(t, 32'h0);
      drive(t);
      exp_stall = 1'b1; exp_req = 1'b0;
      tick();
      exp_valid = 1'b0; exp_req = 1'b1;
      tick();
      chk_en = 1'b0;
      i_rst = 1'b1;
      #1;
      chk("midrst_req", o_dmem_req, 32'd0);
      chk("midrst_stall", o_stall, 32'd0);
      chk("midrst_valid", or_valid, 32'd0);
      chk("midrst_wr_en", or_rd_wr_en, 32'd0);
      chk("midrst_rd_data", or_rd_data, 32'd0);
      chk("midrst_pc", or_pc, 32'd0);
      i_valid = 1'b0;
      tick();
      i_rst = 1'b0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_wb = '0;
      i_dmem_ack = 1'b1; i_dmem_rdata = 32'h12345678;
      chk_en = 1'b1;
      tick();
      i_dmem_ack = 1'b0;
      tick();
      do_instr(mk(OP_LUI, 5'd4, 32'hABCDE000, 32'h0, 3'd0, 32'h84), 0, 32'h0);
      bubble();
      tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
